// File: rtl/addsub_pkg.sv
// Shared constants and state encoding for the bit-serial adder/subtractor.
package addsub_pkg;

    // Default operand/result width.
    localparam int ADDSUB_W = 4;

    // Controller states; the encodings are fixed so other blocks can decode them.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fa_bit.sv
// One-bit full adder: the only arithmetic cell in the serial datapath.
module fa_bit
    import addsub_pkg::*;
(
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry for a single bit position.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial two's-complement adder/subtractor. An operand pair is taken
// over a valid/ready handshake, evaluated LSB first through one full-adder
// cell with a registered carry, and offered with carry/overflow flags over
// a second valid/ready handshake.
module serial_addsub
    import addsub_pkg::*;
#(
    parameter int WIDTH = ADDSUB_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    // Bit index whose carry-out is the carry into the MSB.
    localparam logic [CW-1:0] CNT_MSB_IN = CW'(WIDTH - 2);
    // Bit index of the MSB; processing it ends the run.
    localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_next;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic [WIDTH-1:0] r_res_sh;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_c_msb_in;
    logic [WIDTH-1:0] w_b_inv;
    logic             w_s;
    logic             w_co;

    // Subtraction is A + ~B + 1: invert B here, the +1 comes in as initial carry.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_b_inv
            assign w_b_inv[gi] = b[gi] ^ sub;
        end
    endgenerate

    fa_bit u_fa_bit (
        .a  (r_a_sh[0]),
        .b  (r_b_sh[0]),
        .ci (r_carry),
        .s  (w_s),
        .co (w_co)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode: accept in IDLE, WIDTH bit steps in RUN, hold in DONE until taken.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)           w_state_next = ST_RUN;
            ST_RUN:  if (r_cnt == CNT_LAST)  w_state_next = ST_DONE;
            ST_DONE: if (out_ready)          w_state_next = ST_IDLE;
            default:                         w_state_next = ST_IDLE;
        endcase
    end

    // Datapath: operand capture on accept, one bit per cycle while running.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh     <= '0;
            r_b_sh     <= '0;
            r_res_sh   <= '0;
            r_cnt      <= '0;
            r_carry    <= 1'b0;
            r_c_msb_in <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a_sh     <= a;
                        r_b_sh     <= w_b_inv;
                        r_carry    <= sub;
                        r_cnt      <= '0;
                        r_c_msb_in <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_res_sh <= {w_s, r_res_sh[WIDTH-1:1]};
                    r_carry  <= w_co;
                    r_cnt    <= r_cnt + CW'(1);
                    if (r_cnt == CNT_MSB_IN) begin
                        r_c_msb_in <= w_co;
                    end
                end
                default: begin
                    // DONE holds everything stable until the consumer takes it.
                end
            endcase
        end
    end

    // Handshake and result outputs come straight from registers.
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        result    = r_res_sh;
        cout      = r_carry;
        ovf       = r_c_msb_in ^ r_carry;
    end

endmodule
